// File: rtl/bcd_digit_encoder_if.sv
// -----------------------------------------------------------------------------
// bcd_digit_encoder_if
// Handshake/result bundle between a binary value source and bcd_digit_encoder.
//   master : drives start/bin, observes busy/done/digits/overflow
//   slave  : the encoder side
// Signals:
//   start    conversion request
//   bin      unsigned binary value (WIDTH bits)
//   busy     conversion in progress
//   done     one-cycle pulse when digits update
//   ones/tens/hundreds  BCD digit nibbles
//   overflow last converted value exceeded 999
// -----------------------------------------------------------------------------
interface bcd_digit_encoder_if #(
   parameter int WIDTH = 10
);
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             busy;
   logic             done;
   logic [3:0]       ones;
   logic [3:0]       tens;
   logic [3:0]       hundreds;
   logic             overflow;

   modport master (
      output start, bin,
      input  busy, done, ones, tens, hundreds, overflow
   );

   modport slave (
      input  start, bin,
      output busy, done, ones, tens, hundreds, overflow
   );
endinterface

// File: rtl/bcd_digit_encoder.sv
// -----------------------------------------------------------------------------
// bcd_digit_encoder
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// feeding the seven-segment display path. The last completed result is held
// on the outputs so the display never sees partial values.
//
// Parameters:
//   WIDTH  binary input width, legal range 4..13 (thousands nibble never
//          overflows within that range)
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset; aborts any conversion
//   bus    bcd_digit_encoder_if.slave (start, bin, busy, done, ones, tens,
//          hundreds, overflow); all outputs are registered
// Build option:
//   BCD_ENC_SATURATE_EN  when defined, values >999 display as 9/9/9;
//                        otherwise the low three digits are shown. overflow
//                        is flagged in both builds.
// Latency: start accepted at edge E0, done pulses after edge E(WIDTH+1).
// -----------------------------------------------------------------------------
module bcd_digit_encoder #(
   parameter int WIDTH = 10
) (
   input logic               clk,
   input logic               reset,
   bcd_digit_encoder_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [15:0]      scratch;
   logic [CW-1:0]    cnt;
   logic [11:0]      adj;

   logic             busy_r;
   logic             done_r;
   logic [3:0]       ones_r;
   logic [3:0]       tens_r;
   logic [3:0]       hundreds_r;
   logic             overflow_r;

   // Add-3 correction on the units/tens/hundreds nibbles. The thousands
   // nibble never needs it: reaching 5 there before the last shift would
   // imply a final value >= 10000, outside the legal WIDTH range.
   always_comb begin
      adj = scratch[11:0];
      for (int unsigned i = 0; i < 3; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sr         <= '0;
         scratch    <= '0;
         cnt        <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ones_r     <= '0;
         tens_r     <= '0;
         hundreds_r <= '0;
         overflow_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sr      <= bus.bin;
                  scratch <= '0;
                  cnt     <= CW'(WIDTH);
                  busy_r  <= 1'b1;
                  state   <= SHIFT;
               end
            end

            SHIFT: begin
               scratch <= {scratch[14:12], adj, sr[WIDTH-1]};
               sr      <= {sr[WIDTH-2:0], 1'b0};
               cnt     <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state <= DONE;
               end
            end

            DONE: begin
`ifdef BCD_ENC_SATURATE_EN
               if (scratch[15:12] != 4'd0) begin
                  ones_r     <= 4'd9;
                  tens_r     <= 4'd9;
                  hundreds_r <= 4'd9;
               end else begin
                  ones_r     <= scratch[3:0];
                  tens_r     <= scratch[7:4];
                  hundreds_r <= scratch[11:8];
               end
`else
               ones_r     <= scratch[3:0];
               tens_r     <= scratch[7:4];
               hundreds_r <= scratch[11:8];
`endif
               overflow_r <= (scratch[15:12] != 4'd0);
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.ones     = ones_r;
   assign bus.tens     = tens_r;
   assign bus.hundreds = hundreds_r;
   assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_encoder
// Directed self-checking bench for bcd_digit_encoder at WIDTH=10. Expected
// digits are hand-computed constants; inputs change and outputs are sampled
// 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_digit_encoder;

   localparam int WIDTH = 10;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   bcd_digit_encoder_if #(.WIDTH(WIDTH)) bus ();

   bcd_digit_encoder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // Pulse start for one accepted edge; returns 1 time unit after edge E0.
   task automatic start_conv(input logic [WIDTH-1:0] value);
      bus.bin   = value;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts edges until done is seen (bounded); n = 0 if never seen.
   task automatic wait_done(output int n);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones} !== 12'h000) begin
         errors++; $display("FAIL reset_digits: got %h required 000", {bus.hundreds, bus.tens, bus.ones});
      end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", bus.busy); end
   endtask

   task automatic test_convert();
      logic [9:0]  vals [5];
      logic [11:0] exp_d [5];
      logic        exp_o [5];
      int          n;
      vals[0] = 10'd0;    exp_d[0] = 12'h000; exp_o[0] = 1'b0;
      vals[1] = 10'd255;  exp_d[1] = 12'h255; exp_o[1] = 1'b0;
      vals[2] = 10'd999;  exp_d[2] = 12'h999; exp_o[2] = 1'b0;
`ifdef BCD_ENC_SATURATE_EN
      vals[3] = 10'd1023; exp_d[3] = 12'h999; exp_o[3] = 1'b1;
`else
      vals[3] = 10'd1023; exp_d[3] = 12'h023; exp_o[3] = 1'b1;
`endif
      vals[4] = 10'd58;   exp_d[4] = 12'h058; exp_o[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start_conv(vals[i]);
         checks++;
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL conv_busy_%0d: got %b required 1", vals[i], bus.busy); end
         wait_done(n);
         checks++;
         if (n != 11) begin errors++; $display("FAIL conv_latency_%0d: got %0d required 11", vals[i], n); end
         checks++;
         if ({bus.hundreds, bus.tens, bus.ones} !== exp_d[i]) begin
            errors++; $display("FAIL conv_digits_%0d: got %h required %h", vals[i], {bus.hundreds, bus.tens, bus.ones}, exp_d[i]);
         end
         checks++;
         if (bus.overflow !== exp_o[i]) begin
            errors++; $display("FAIL conv_overflow_%0d: got %b required %b", vals[i], bus.overflow, exp_o[i]);
         end
         checks++;
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL conv_busy_end_%0d: got %b required 0", vals[i], bus.busy); end
         // result must hold and done must not repeat
         repeat (3) @(posedge clk);
         #1;
         checks++;
         if (bus.done !== 1'b0 || {bus.hundreds, bus.tens, bus.ones} !== exp_d[i]) begin
            errors++; $display("FAIL conv_hold_%0d: got done=%b digits=%h required done=0 digits=%h",
                               vals[i], bus.done, {bus.hundreds, bus.tens, bus.ones}, exp_d[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int dones;
      int busy_drop;
      int n;
      start_conv(10'd512);
      busy_drop = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b1) busy_drop++;
      end
      bus.bin   = 10'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_drop++;
      n = 0;
      for (int k = 5; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            n = k;
            break;
         end
         if (bus.busy !== 1'b1) busy_drop++;
      end
      checks++;
      if (n != 11) begin errors++; $display("FAIL swb_latency: got %0d required 11", n); end
      checks++;
      if (busy_drop != 0) begin errors++; $display("FAIL swb_busy_gap: got %0d low cycles required 0", busy_drop); end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones} !== 12'h512) begin
         errors++; $display("FAIL swb_digits: got %h required 512", {bus.hundreds, bus.tens, bus.ones});
      end
      dones = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL swb_queued: got %0d extra active cycles required 0", dones); end
   endtask

   task automatic test_reset_mid();
      int dones;
      int n;
      start_conv(10'd777);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_flags: got busy=%b done=%b required 0/0", bus.busy, bus.done);
      end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones, bus.overflow} !== 13'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got %h ovf=%b required 000 ovf=0", {bus.hundreds, bus.tens, bus.ones}, bus.overflow);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      dones = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL rst_mid_resume: got %0d active cycles required 0", dones); end
      start_conv(10'd42);
      wait_done(n);
      checks++;
      if (n != 11) begin errors++; $display("FAIL rst_fresh_latency: got %0d required 11", n); end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones} !== 12'h042) begin
         errors++; $display("FAIL rst_fresh_digits: got %h required 042", {bus.hundreds, bus.tens, bus.ones});
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start_conv(10'd100);
      repeat (4) @(posedge clk);
      #1;
      bus.bin = 10'd555;   // must not disturb the 100 conversion
      wait_done(n);
      checks++;
      if (n != 7) begin errors++; $display("FAIL b2b_first_latency: got %0d required 7", n); end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones} !== 12'h100) begin
         errors++; $display("FAIL b2b_first_digits: got %h required 100", {bus.hundreds, bus.tens, bus.ones});
      end
      // start presented during the done cycle
      bus.bin   = 10'd321;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || {bus.hundreds, bus.tens, bus.ones} !== 12'h100) begin
         errors++; $display("FAIL b2b_accept: got busy=%b digits=%h required busy=1 digits=100",
                            bus.busy, {bus.hundreds, bus.tens, bus.ones});
      end
      repeat (2) @(posedge clk);
      #1;
      bus.bin = 10'd999;   // ignored mid-conversion
      wait_done(n);
      checks++;
      if (n + 3 != 12) begin errors++; $display("FAIL b2b_spacing: got %0d required 12", n + 3); end
      checks++;
      if ({bus.hundreds, bus.tens, bus.ones} !== 12'h321 || bus.overflow !== 1'b0) begin
         errors++; $display("FAIL b2b_second_digits: got %h ovf=%b required 321 ovf=0",
                            {bus.hundreds, bus.tens, bus.ones}, bus.overflow);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.bin   = '0;
      test_reset();
      test_convert();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
